// File: rtl/scene_pkg.sv
// Scene IDs shared by the scene controller and the scene multiplexer.
// The scene state type reuses these encodings directly.
package scene_pkg;

  localparam logic [1:0] MENU_ID      = 2'b00;
  localparam logic [1:0] BATTLE_ID    = 2'b01;
  localparam logic [1:0] ENDGAME_ID   = 2'b10;
  localparam logic [1:0] HOWTOPLAY_ID = 2'b11;

  typedef enum logic [1:0] {
    S_MENU    = MENU_ID,
    S_BATTLE  = BATTLE_ID,
    S_ENDGAME = ENDGAME_ID,
    S_HOWTO   = HOWTOPLAY_ID
  } scene_e;

endpackage

// File: rtl/scene_ctl_btn_debounce.sv
// Button debouncer: one press pulse after CYCLES consecutive high cycles.
// Holding the button does not repeat; release clears the count.
module btn_debounce #(
  parameter int CYCLES = 65000
) (
  input  logic i_pclk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] MAX  = W'(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  // saturating high-time counter; pulse in the cycle it hits MAX
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      o_press <= i_raw && (cnt == LAST);
      if (!i_raw)
        cnt <= '0;
      else if (cnt != MAX)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scene_ctl.sv
// Game-flow scene controller: debounced buttons raise scene requests,
// which are held pending and committed only at a vsync rising edge.
module scene_ctl #(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int ENDGAME_FRAMES  = 300
) (
  input  logic       i_pclk,
  input  logic       i_rst,
  input  logic       i_vs,
  input  logic       i_btn_start,
  input  logic       i_btn_help,
  input  logic       i_btn_back,
  input  logic       i_game_over,
  output logic [1:0] o_sel,
  output logic       o_battle_init,
  output logic       o_scene_changed
);

  import scene_pkg::*;

  localparam int FW = $clog2(ENDGAME_FRAMES + 1);
  localparam logic [FW-1:0] FMAX  = FW'(ENDGAME_FRAMES);
  localparam logic [FW-1:0] FLAST = FW'(ENDGAME_FRAMES - 1);

  logic start, help, back;
  logic vs_d, go_d;
  logic frame, go_ev, any_btn, commit;
  logic pend, pend_nx;
  logic cand;
  logic tmo;
  logic [FW-1:0] fcnt;
  scene_e state, state_nx;
  scene_e tgt, tgt_nx, cand_tgt;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start (
    .i_pclk(i_pclk), .i_rst(i_rst),
    .i_raw(i_btn_start), .o_press(start)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_help (
    .i_pclk(i_pclk), .i_rst(i_rst),
    .i_raw(i_btn_help), .o_press(help)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_back (
    .i_pclk(i_pclk), .i_rst(i_rst),
    .i_raw(i_btn_back), .o_press(back)
  );

  assign frame   = i_vs & ~vs_d;
  assign go_ev   = i_game_over & ~go_d;
  assign any_btn = start | help | back;
  assign commit  = frame & pend;
  assign o_sel   = state;

  // edge-detect delay flops for vsync and game over
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      vs_d <= 1'b0;
      go_d <= 1'b0;
    end else begin
      vs_d <= i_vs;
      go_d <= i_game_over;
    end
  end

  // candidate target from current scene; earlier branch wins
  always_comb begin
    cand     = 1'b0;
    cand_tgt = state;
    unique case (state)
      S_MENU: begin
        if (start) begin
          cand = 1'b1; cand_tgt = S_BATTLE;
        end else if (help) begin
          cand = 1'b1; cand_tgt = S_HOWTO;
        end
      end
      S_BATTLE: begin
        if (go_ev) begin
          cand = 1'b1; cand_tgt = S_ENDGAME;
        end
      end
      S_ENDGAME: begin
        if (start) begin
          cand = 1'b1; cand_tgt = S_BATTLE;
        end else if (back || tmo) begin
          cand = 1'b1; cand_tgt = S_MENU;
        end
      end
      S_HOWTO: begin
        if (back) begin
          cand = 1'b1; cand_tgt = S_MENU;
        end
      end
    endcase
  end

  // commit pending at frame boundary, else latch first candidate
  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    tgt_nx   = tgt;
    if (commit) begin
      state_nx = tgt;
      pend_nx  = 1'b0;
    end else if (!pend && cand) begin
      pend_nx = 1'b1;
      tgt_nx  = cand_tgt;
    end
  end

  // scene state, pending request and change pulses
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state           <= S_MENU;
      pend            <= 1'b0;
      tgt             <= S_MENU;
      o_scene_changed <= 1'b0;
      o_battle_init   <= 1'b0;
    end else begin
      state           <= state_nx;
      pend            <= pend_nx;
      tgt             <= tgt_nx;
      o_scene_changed <= commit;
      o_battle_init   <= commit && (tgt == S_BATTLE);
    end
  end

  // idle-frame counter in ENDGAME; one-cycle timeout on reaching max
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      fcnt <= '0;
      tmo  <= 1'b0;
    end else begin
      tmo <= 1'b0;
      if (state != S_ENDGAME || any_btn) begin
        fcnt <= '0;
      end else if (frame && fcnt != FMAX) begin
        fcnt <= fcnt + 1'b1;
        tmo  <= (fcnt == FLAST);
      end
    end
  end

endmodule

// File: tb/tb_scene_ctl.sv
// Directed bench for scene_ctl with short debounce and timeout.
// Inputs change on negedge, vsync just after posedge, checks on negedge.
module tb_scene_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0;
  logic [2:0] btn = 3'b000;
  logic       go = 1'b0;
  logic [1:0] sel;
  logic       binit;
  logic       chg;

  int nvec = 0;
  int nmis = 0;
  int vc = 10;
  int bnd_cnt = 0;
  int nbinit = 0;

  scene_ctl #(
    .DEBOUNCE_CYCLES(4),
    .ENDGAME_FRAMES(3)
  ) dut (
    .i_pclk(clk),
    .i_rst(rst),
    .i_vs(vs),
    .i_btn_start(btn[0]),
    .i_btn_help(btn[1]),
    .i_btn_back(btn[2]),
    .i_game_over(go),
    .o_sel(sel),
    .o_battle_init(binit),
    .o_scene_changed(chg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    vc = (vc == 49) ? 0 : vc + 1;
    if (vc == 0) bnd_cnt++;
    vs = (vc < 5);
  end

  always @(negedge clk) begin
    if (binit) nbinit++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_bnd();
    int b;
    b = bnd_cnt;
    for (int i = 0; i < 120 && bnd_cnt == b; i++)
      @(negedge clk);
    if (bnd_cnt == b) begin
      nvec++;
      nmis++;
      $display("FAIL bnd_timeout: got no boundary exp one");
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [2:0] m, input int n);
    @(negedge clk);
    btn = m;
    repeat (n) @(negedge clk);
    btn = 3'b000;
  endtask

  task automatic go_pulse();
    @(negedge clk);
    go = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b0;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_binit", 32'(binit), 32'h0);
    chk("rst_chg", 32'(chg), 32'h0);
    rst = 1'b0;

    for (int f = 0; f < 3; f++) begin
      wait_bnd();
      chk("idle_sel", 32'(sel), 32'h0);
      chk("idle_chg", 32'(chg), 32'h0);
    end

    hold(3'b001, 3);
    wait_bnd();
    chk("short_start", 32'(sel), 32'h0);

    hold(3'b001, 10);
    wait_bnd();
    chk("start_sel", 32'(sel), 32'h1);
    chk("start_binit", 32'(binit), 32'h1);
    chk("start_chg", 32'(chg), 32'h1);
    @(negedge clk);
    chk("start_binit_end", 32'(binit), 32'h0);
    chk("start_chg_end", 32'(chg), 32'h0);

    hold(3'b001, 10);
    wait_bnd();
    chk("battle_start_ign", 32'(sel), 32'h1);
    chk("battle_no_chg", 32'(chg), 32'h0);

    go_pulse();
    wait_bnd();
    chk("go_sel", 32'(sel), 32'h2);
    chk("go_chg", 32'(chg), 32'h1);
    chk("go_binit", 32'(binit), 32'h0);

    for (int f = 1; f <= 3; f++) begin
      wait_bnd();
      chk("eg_wait_sel", 32'(sel), 32'h2);
    end
    wait_bnd();
    chk("eg_tmo_sel", 32'(sel), 32'h0);
    chk("eg_tmo_chg", 32'(chg), 32'h1);

    hold(3'b001, 10);
    wait_bnd();
    chk("menu2_start", 32'(sel), 32'h1);
    go_pulse();
    wait_bnd();
    chk("go2_sel", 32'(sel), 32'h2);
    wait_bnd();
    chk("eg2_f1_sel", 32'(sel), 32'h2);
    hold(3'b001, 10);
    wait_bnd();
    chk("rematch_sel", 32'(sel), 32'h1);
    chk("rematch_binit", 32'(binit), 32'h1);

    go_pulse();
    repeat (4) @(negedge clk);
    do_rst();
    chk("midrst_sel", 32'(sel), 32'h0);
    chk("midrst_chg", 32'(chg), 32'h0);
    wait_bnd();
    chk("midrst_bnd_sel", 32'(sel), 32'h0);
    chk("midrst_bnd_chg", 32'(chg), 32'h0);

    hold(3'b011, 10);
    hold(3'b100, 8);
    wait_bnd();
    chk("prio_sel", 32'(sel), 32'h1);
    chk("prio_binit", 32'(binit), 32'h1);
    chk("prio_chg", 32'(chg), 32'h1);

    do_rst();
    hold(3'b010, 10);
    wait_bnd();
    chk("help_sel", 32'(sel), 32'h3);
    chk("help_binit", 32'(binit), 32'h0);
    hold(3'b001, 10);
    wait_bnd();
    chk("howto_start_ign", 32'(sel), 32'h3);
    hold(3'b100, 10);
    wait_bnd();
    chk("howto_back", 32'(sel), 32'h0);

    chk("binit_total", 32'(nbinit), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
